interrupt_ctrl: RTL and testbench



---
 rtl/interrupt_ctrl.sv | 83 ++++++++
 tb/tb_interrupt_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/interrupt_ctrl.sv
// Single-level interrupt controller: it latches the highest-priority pending line,
// issues a one-cycle trap request, waits for MRET, then acknowledges that line.
module interrupt_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] irq_i,
  input  logic [31:0] mie_i,
  input  logic        stall_i,
  input  logic        mret_i,
  output logic        int_o,
  output logic [31:0] mcause_o,
  output logic [15:0] irq_ret_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, TRAP, BUSY, ACK} state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q;
  logic [31:0] mcause_q;
  logic [15:0] pend;
  logic        accept;
  logic        unused_mie_hi;

  // Bit 0 has the highest priority, so scan downward and keep the last hit.
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  assign pend          = irq_i & mie_i[15:0];
  assign unused_mie_hi = ^mie_i[31:16];

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    int_o     = 1'b0;
    irq_ret_o = '0;
    busy_o    = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (pend != '0 && !stall_i) begin
          accept  = 1'b1;
          state_d = TRAP;
        end
      end
      TRAP: begin
        int_o   = 1'b1;
        state_d = BUSY;
      end
      BUSY: begin
        if (mret_i) state_d = ACK;
      end
      ACK: begin
        irq_ret_o = 16'b1 << idx_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The source index and cause are committed only on the edge that enters TRAP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      mcause_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q    <= lowest_set(pend);
        mcause_q <= {1'b1, 26'b0, 1'b1, lowest_set(pend)};
      end
    end
  end

  assign mcause_o = mcause_q;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Bench for interrupt_ctrl: a directed vector table followed by randomized traffic
// compared against a behavioural model of the handler lifecycle.
module tb_interrupt_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] irq = '0;
  logic [31:0] mie = '0;
  logic        stall = 1'b0;
  logic        mret = 1'b0;
  logic        int_o;
  logic [31:0] mcause_o;
  logic [15:0] irq_ret_o;
  logic        busy_o;

  int n_vec = 0;
  int n_bad = 0;

  interrupt_ctrl dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .irq_i    (irq),
    .mie_i    (mie),
    .stall_i  (stall),
    .mret_i   (mret),
    .int_o    (int_o),
    .mcause_o (mcause_o),
    .irq_ret_o(irq_ret_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] irq;
    logic [31:0] mie;
    logic        stall;
    logic        mret;
    logic        e_int;
    logic [31:0] e_cause;
    logic [15:0] e_ret;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: a handler is "active" from acceptance until the cycle after
  // the acknowledge; age counts cycles since acceptance.
  bit          m_active = 0;
  bit          m_ret = 0;
  int          m_age = 0;
  logic [3:0]  m_idx = '0;
  logic [31:0] m_cause = '0;

  task automatic add(input logic r, input logic [15:0] i, input logic [31:0] m,
                     input logic s, input logic mr, input logic ei,
                     input logic [31:0] ec, input logic [15:0] er, input logic eb);
    vec_t v;
    v.rst = r; v.irq = i; v.mie = m; v.stall = s; v.mret = mr;
    v.e_int = ei; v.e_cause = ec; v.e_ret = er; v.e_busy = eb;
    tbl.push_back(v);
  endtask

  task automatic model_edge();
    logic [15:0] p, iso;
    p = irq & mie[15:0];
    if (rst) begin
      m_active = 0; m_ret = 0; m_age = 0; m_idx = '0; m_cause = '0;
    end else if (!m_active) begin
      if (p != 0 && !stall) begin
        iso      = p & (~p + 16'd1);
        m_idx    = 4'($clog2(iso));
        m_cause  = 32'h8000_0010 + 32'(m_idx);
        m_active = 1; m_ret = 0; m_age = 0;
      end
    end else if (m_ret) begin
      m_active = 0; m_ret = 0;
    end else begin
      if (m_age >= 1 && mret) m_ret = 1;
      m_age++;
    end
  endtask

  task automatic check(input string name, input logic ei, input logic [31:0] ec,
                       input logic [15:0] er, input logic eb);
    n_vec++;
    if (int_o !== ei || mcause_o !== ec || irq_ret_o !== er || busy_o !== eb) begin
      n_bad++;
      $display("FAIL %s: got int=%0b cause=%h ret=%h busy=%0b, want int=%0b cause=%h ret=%h busy=%0b",
               name, int_o, mcause_o, irq_ret_o, busy_o, ei, ec, er, eb);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    //  rst irq       mie           st mr  int cause          ret       busy
    // reset
    add(1, 16'h0000, 32'h0000_0000, 0, 0, 0, 32'h0,          16'h0000, 0);
    add(1, 16'h0004, 32'h0000_0004, 0, 0, 0, 32'h0,          16'h0000, 0);
    // single line 2
    add(0, 16'h0004, 32'h0000_0004, 0, 0, 1, 32'h8000_0012, 16'h0000, 1);
    add(0, 16'h0000, 32'h0000_0000, 0, 0, 0, 32'h8000_0012, 16'h0000, 1);
    add(0, 16'h0000, 32'h0000_0000, 0, 1, 0, 32'h8000_0012, 16'h0004, 1);
    add(0, 16'h0000, 32'h0000_0000, 0, 0, 0, 32'h8000_0012, 16'h0000, 0);
    // priority: lines 3 and 5 -> 3
    add(0, 16'h0028, 32'h0000_FFFF, 0, 0, 1, 32'h8000_0013, 16'h0000, 1);
    add(0, 16'h0028, 32'h0000_FFFF, 0, 0, 0, 32'h8000_0013, 16'h0000, 1);
    add(0, 16'h0028, 32'h0000_FFFF, 0, 1, 0, 32'h8000_0013, 16'h0008, 1);
    add(0, 16'h0000, 32'h0000_FFFF, 0, 0, 0, 32'h8000_0013, 16'h0000, 0);
    // masked by the ignored upper half of mie
    add(0, 16'h0001, 32'hFFFF_0000, 0, 0, 0, 32'h8000_0013, 16'h0000, 0);
    add(0, 16'h0001, 32'hFFFF_0000, 0, 0, 0, 32'h8000_0013, 16'h0000, 0);
    // stall holds off acceptance for 5 cycles
    for (int k = 0; k < 5; k++)
      add(0, 16'h0002, 32'h0000_FFFF, 1, 0, 0, 32'h8000_0013, 16'h0000, 0);
    add(0, 16'h0002, 32'h0000_FFFF, 0, 0, 1, 32'h8000_0011, 16'h0000, 1);
    add(0, 16'h0000, 32'h0000_FFFF, 0, 0, 0, 32'h8000_0011, 16'h0000, 1);
    add(0, 16'h0000, 32'h0000_FFFF, 0, 1, 0, 32'h8000_0011, 16'h0002, 1);
    add(0, 16'h0000, 32'h0000_FFFF, 0, 0, 0, 32'h8000_0011, 16'h0000, 0);
    // committed source survives irq changes; mret in TRAP ignored
    add(0, 16'h0100, 32'h0000_FFFF, 0, 0, 1, 32'h8000_0018, 16'h0000, 1);
    add(0, 16'h0001, 32'h0000_FFFF, 0, 1, 0, 32'h8000_0018, 16'h0000, 1);
    add(0, 16'h0001, 32'h0000_FFFF, 1, 0, 0, 32'h8000_0018, 16'h0000, 1);
    add(0, 16'h0001, 32'h0000_FFFF, 0, 1, 0, 32'h8000_0018, 16'h0100, 1);
    add(0, 16'h0000, 32'h0000_FFFF, 0, 0, 0, 32'h8000_0018, 16'h0000, 0);
    // reset during BUSY abandons line 15
    add(0, 16'h8000, 32'h0000_FFFF, 0, 0, 1, 32'h8000_001F, 16'h0000, 1);
    add(0, 16'h0000, 32'h0000_FFFF, 0, 0, 0, 32'h8000_001F, 16'h0000, 1);
    add(1, 16'h0000, 32'h0000_FFFF, 0, 1, 0, 32'h0,          16'h0000, 0);
    add(0, 16'h0000, 32'h0000_FFFF, 0, 1, 0, 32'h0,          16'h0000, 0);
    // reset during TRAP; accepted right after reset deasserts
    add(0, 16'h0010, 32'h0000_FFFF, 0, 0, 1, 32'h8000_0014, 16'h0000, 1);
    add(1, 16'h0010, 32'h0000_FFFF, 0, 0, 0, 32'h0,          16'h0000, 0);
    add(0, 16'h0000, 32'h0000_FFFF, 0, 1, 0, 32'h0,          16'h0000, 0);
    // back-to-back on a held request; mret in ACK ignored
    add(0, 16'h0003, 32'h0000_FFFF, 0, 0, 1, 32'h8000_0010, 16'h0000, 1);
    add(0, 16'h0003, 32'h0000_FFFF, 0, 0, 0, 32'h8000_0010, 16'h0000, 1);
    add(0, 16'h0003, 32'h0000_FFFF, 0, 1, 0, 32'h8000_0010, 16'h0001, 1);
    add(0, 16'h0003, 32'h0000_FFFF, 0, 1, 0, 32'h8000_0010, 16'h0000, 0);
    add(0, 16'h0003, 32'h0000_FFFF, 0, 0, 1, 32'h8000_0010, 16'h0000, 1);
    add(0, 16'h0000, 32'h0000_FFFF, 0, 0, 0, 32'h8000_0010, 16'h0000, 1);
    add(0, 16'h0000, 32'h0000_FFFF, 0, 1, 0, 32'h8000_0010, 16'h0001, 1);
    add(0, 16'h0000, 32'h0000_FFFF, 0, 1, 0, 32'h8000_0010, 16'h0000, 0);

    #1;
    for (int k = 0; k < tbl.size(); k++) begin
      rst = tbl[k].rst; irq = tbl[k].irq; mie = tbl[k].mie;
      stall = tbl[k].stall; mret = tbl[k].mret;
      step();
      check($sformatf("vec%0d", k), tbl[k].e_int, tbl[k].e_cause, tbl[k].e_ret, tbl[k].e_busy);
    end

    // Randomized traffic; a reset first brings model and DUT into step.
    rst = 1; irq = '0; mie = '0; stall = 0; mret = 0;
    step();
    check("rnd_reset", 1'b0, 32'h0, 16'h0, 1'b0);
    for (int k = 0; k < 600; k++) begin
      logic [15:0] r;
      rst   = ($urandom_range(0, 63) == 0);
      r     = 16'($urandom);
      irq   = ($urandom_range(0, 2) == 0) ? r : (r & 16'($urandom) & 16'($urandom));
      mie   = $urandom;
      stall = ($urandom_range(0, 3) == 0);
      mret  = ($urandom_range(0, 2) == 0);
      step();
      check($sformatf("rnd%0d", k), (m_active && m_age == 0), m_cause,
            (m_active && m_ret) ? (16'd1 << m_idx) : 16'h0, m_active);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
